decode_stage: RTL and testbench
===============================

# decode_stage

Second pipeline stage of the MIPS core, directly downstream of fetch. Splits the fetched instruction word into fields and holds the 32×32 register file. Computes the extended immediate and destination register, and registers everything toward execute. Detects load-use hazards, inserts bubbles, and holds fetch via `stall_fetch`. Bit numbering is big-endian throughout: bit 0 is the MSB.

## Interface
- `LOAD_USE_STALLS`, default 1: number of bubbles inserted per load-use hazard. Legal range is 1–7.
- `clock`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-high.
- `insn_decode`  in  [0:31]: instruction word from fetch.
- `pc`  in  [0:31]: PC of `insn_decode`.
- `insn_valid`  in  1: `insn_decode`/`pc` carry a real instruction.
- `flush`  in  1: branch or jump taken in execute; discard the current decode slot.
- `wb_wren`  in  1: register-file write enable from writeback.
- `wb_rd`  in  [0:4]: writeback destination.
- `wb_data`  in  [0:31]: writeback data.
- `stall_fetch`  out  1: combinational. High means fetch must hold its outputs and not advance `pc`.
- `valid_execute`  out  1: execute slot holds a real instruction.
- `pc_execute`, `insn_execute`  out  [0:31]: PC and word passed down.
- `rs_data`, `rt_data`  out  [0:31]: register operands.
- `imm_ext`  out  [0:31]: extended immediate.
- `rd_dest`  out  [0:4]: write destination.
- `reg_wren`, `mem_read`, `mem_wren`  out  1: control bits.

## Operation
- Field decode:
  - opcode = [0:5], rs = [6:10], rt = [11:15], rd = [16:20], funct = [26:31], imm = [16:31].
- Immediate:
  - zero-extended for ANDI/ORI/XORI (opcodes 0x0C/0x0D/0x0E);
  - imm followed by 16 zero bits for LUI (0x0F);
  - sign-extended otherwise.
- Destination:
  - R-type (opcode 0) uses rd;
  - I-type ALU ops and loads (0x20–0x25) use rt;
  - JAL (0x03) uses 31.
- `reg_wren` is 0 for stores (0x28–0x2B), branches, J and JR. `reg_wren` is also forced to 0 whenever the destination is 0.
- Register file:
  - r0 always reads 0;
  - writes to r0 are ignored;
  - writes happen at the rising edge when `wb_wren` is high.
- Hazard detect is asserted only in RUN, when all of these hold:
  - `valid_execute` && `mem_read` && `rd_dest` != 0;
  - `rd_dest` equals rs, or equals rt for R-type, stores and branches;
  - `insn_valid` is high.
- FSM states: RUN, HAZARD, with a 3-bit `stall_cnt`.
  - RUN, detect, LOAD_USE_STALLS = 1: issue a bubble; stay in RUN.
  - RUN, detect, LOAD_USE_STALLS > 1: issue a bubble; `stall_cnt` <= LOAD_USE_STALLS−1; go to HAZARD.
  - HAZARD: issue a bubble and decrement `stall_cnt`; at the edge where `stall_cnt` == 1, go to RUN.
- `stall_fetch` = (state == HAZARD) || detect. It is forced to 0 when `flush` is high.
- Bubble: `valid_execute` <= 0, `reg_wren`/`mem_read`/`mem_wren` <= 0, all other outputs hold.
- `flush` has priority over everything: `valid_execute` <= 0, control bits <= 0, state <= RUN, `stall_cnt` <= 0.
- `insn_valid` low without a hazard produces a bubble.

## Timing
- Latency: one cycle from `insn_decode` to the `*_execute` outputs.
- Hazard timing: `stall_fetch` rises in the same cycle the dependent instruction sits at `insn_decode`. Fetch holds, so the same word is re-decoded after the bubbles.
- Reset, asynchronous, all outputs:
  - all registered outputs are 0 and `valid_execute` is 0;
  - state is RUN and `stall_cnt` is 0;
  - all 32 registers are 0;
  - `stall_fetch` is 0.
- Reset asserted mid-HAZARD returns to RUN immediately, with no residual stall.
- Simultaneous `flush` and detect: flush wins; `stall_fetch` is 0.
- Writeback to the same register being read in the same cycle: see Configuration.

## Configuration
- `DECODE_BYPASS_EN` defined: same-cycle writeback to rs/rt is forwarded.
  - `rs_data`/`rt_data` take `wb_data` when `wb_wren` && `wb_rd` == src && src != 0.
- Not defined: `rs_data`/`rt_data` return the pre-write register contents. Software must space dependent instructions.

## Structure
- Shared package `mips_pkg`:
  - opcode/funct localparams (OP_RTYPE, OP_J, OP_JAL, OP_LUI, OP_LW, …);
  - the decode-FSM state enum {RUN, HAZARD};
  - field-slice constants.
- One sub-module, `regfile`: 32×32, two asynchronous read ports, one synchronous write port, async reset, and an optional bypass.

## Test plan
- Reset, then `insn_decode` = 0x2008_0005 (ADDI r8,r0,5), `pc` = 0x8002_0000, `insn_valid` = 1 → next cycle:
  - `valid_execute` = 1, `rd_dest` = 8, `imm_ext` = 0x0000_0005, `reg_wren` = 1, `pc_execute` = 0x8002_0000.
- ORI with imm 0xFFFF → `imm_ext` = 0x0000_FFFF. ADDI with imm 0xFFFF → `imm_ext` = 0xFFFF_FFFF. LUI 0x1234 → `imm_ext` = 0x1234_0000.
- Load-use hazard:
  - sequence: LW r9,0(r8) then ADD r10,r9,r9, with LOAD_USE_STALLS = 1 → `stall_fetch` = 1 for exactly one cycle, one bubble, then ADD issues with `valid_execute` = 1;
  - repeat with LOAD_USE_STALLS = 3 → three bubbles.
- `flush` asserted during HAZARD → `stall_fetch` = 0 in that cycle; next cycle `valid_execute` = 0 and state is RUN.
- Writeback `wb_rd` = 5, `wb_data` = 0xDEAD_BEEF, in the same cycle as a read of r5:
  - with `DECODE_BYPASS_EN` → `rs_data` = 0xDEAD_BEEF;
  - without it → old value, then 0xDEAD_BEEF on the next read.
- Write to r0 with 0xFFFF_FFFF, then read r0 → 0. Assert `reset` mid-stream → all outputs 0 asynchronously.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode/funct codes, instruction field slices,
// decode FSM state type and the decode control bundle with its decoder.
// Bit numbering is big-endian: bit 0 is the MSB of every word.
package mips_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned CNT_W    = 3;

    // Field slices of a 32-bit instruction word (first..last, MSB first)
    localparam int unsigned OPC_FIRST   = 0;
    localparam int unsigned OPC_LAST    = 5;
    localparam int unsigned RS_FIRST    = 6;
    localparam int unsigned RS_LAST     = 10;
    localparam int unsigned RT_FIRST    = 11;
    localparam int unsigned RT_LAST     = 15;
    localparam int unsigned RD_FIRST    = 16;
    localparam int unsigned RD_LAST     = 20;
    localparam int unsigned FUNCT_FIRST = 26;
    localparam int unsigned FUNCT_LAST  = 31;
    localparam int unsigned IMM_FIRST   = 16;
    localparam int unsigned IMM_LAST    = 31;

    localparam logic [0:5] OP_RTYPE  = 6'h00;
    localparam logic [0:5] OP_REGIMM = 6'h01;
    localparam logic [0:5] OP_J      = 6'h02;
    localparam logic [0:5] OP_JAL    = 6'h03;
    localparam logic [0:5] OP_BEQ    = 6'h04;
    localparam logic [0:5] OP_BNE    = 6'h05;
    localparam logic [0:5] OP_BLEZ   = 6'h06;
    localparam logic [0:5] OP_BGTZ   = 6'h07;
    localparam logic [0:5] OP_ADDI   = 6'h08;
    localparam logic [0:5] OP_ANDI   = 6'h0C;
    localparam logic [0:5] OP_ORI    = 6'h0D;
    localparam logic [0:5] OP_XORI   = 6'h0E;
    localparam logic [0:5] OP_LUI    = 6'h0F;
    localparam logic [0:5] OP_LB     = 6'h20;
    localparam logic [0:5] OP_LW     = 6'h23;
    localparam logic [0:5] OP_LHU    = 6'h25;
    localparam logic [0:5] OP_SB     = 6'h28;
    localparam logic [0:5] OP_SW     = 6'h2B;

    localparam logic [0:5] FN_JR     = 6'h08;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HAZARD = 1'b1
    } dec_state_e;

    typedef struct packed {
        logic [0:31] imm_ext;
        logic [0:4]  rd_dest;
        logic        reg_wren;
        logic        mem_read;
        logic        mem_wren;
        logic        uses_rt;
    } dec_ctrl_t;

    // Pure decode of one instruction word into execute-side control.
    function automatic dec_ctrl_t decode_ctrl(input logic [0:31] insn);
        dec_ctrl_t  d;
        logic [0:5] op;
        logic [0:5] fn;
        logic [0:15] imm;
        logic       is_load;
        logic       is_store;
        logic       is_branch;
        logic       is_ialu;
        logic       is_jr;
        op        = insn[OPC_FIRST:OPC_LAST];
        fn        = insn[FUNCT_FIRST:FUNCT_LAST];
        imm       = insn[IMM_FIRST:IMM_LAST];
        is_load   = (op >= OP_LB) && (op <= OP_LHU);
        is_store  = (op >= OP_SB) && (op <= OP_SW);
        is_branch = (op == OP_REGIMM) || ((op >= OP_BEQ) && (op <= OP_BGTZ));
        is_ialu   = (op >= OP_ADDI) && (op <= OP_LUI);
        is_jr     = (op == OP_RTYPE) && (fn == FN_JR);
        d = '0;
        case (op)
            OP_ANDI, OP_ORI, OP_XORI: d.imm_ext = {16'h0000, imm};
            OP_LUI:                   d.imm_ext = {imm, 16'h0000};
            default:                  d.imm_ext = {{16{imm[0]}}, imm};
        endcase
        if (op == OP_RTYPE) begin
            d.rd_dest = insn[RD_FIRST:RD_LAST];
        end else if (is_ialu || is_load) begin
            d.rd_dest = insn[RT_FIRST:RT_LAST];
        end else if (op == OP_JAL) begin
            d.rd_dest = 5'd31;
        end
        // Stores, branches and J leave rd_dest at 0, so only JR needs an explicit kill
        d.reg_wren = (d.rd_dest != 5'd0) && !is_jr;
        d.mem_read = is_load;
        d.mem_wren = is_store;
        d.uses_rt  = (op == OP_RTYPE) || is_store || is_branch;
        return d;
    endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// regfile: 32x32 register file, two asynchronous read ports, one synchronous
// write port, asynchronous active-high reset. r0 reads 0 and ignores writes.
// Optional same-cycle write-to-read forwarding when DECODE_BYPASS_EN is defined;
// otherwise reads return the pre-write contents.
// Ports: clock, reset; rd_addr_a/rd_addr_b -> rd_data_a_c/rd_data_b_c;
//        wr_en, wr_addr, wr_data.
module regfile
    import mips_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [0:4]  rd_addr_a,
    input  logic [0:4]  rd_addr_b,
    output logic [0:31] rd_data_a_c,
    output logic [0:31] rd_data_b_c,
    input  logic        wr_en,
    input  logic [0:4]  wr_addr,
    input  logic [0:31] wr_data
);

    logic [0:31] mem_q [NUM_REGS];
    logic [0:31] mem_d [NUM_REGS];

    // Next-state of the array: single write, r0 never written
    always_comb begin
        mem_d = mem_q;
        if (wr_en && (wr_addr != 5'd0)) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read port A
    always_comb begin
        rd_data_a_c = '0;
        if (rd_addr_a != 5'd0) begin
            rd_data_a_c = mem_q[rd_addr_a];
`ifdef DECODE_BYPASS_EN
            if (wr_en && (wr_addr == rd_addr_a)) begin
                rd_data_a_c = wr_data;
            end
`endif
        end
    end

    // Read port B
    always_comb begin
        rd_data_b_c = '0;
        if (rd_addr_b != 5'd0) begin
            rd_data_b_c = mem_q[rd_addr_b];
`ifdef DECODE_BYPASS_EN
            if (wr_en && (wr_addr == rd_addr_b)) begin
                rd_data_b_c = wr_data;
            end
`endif
        end
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: MIPS decode. Splits the fetched word into fields, reads the
// register file, extends the immediate, picks the destination and registers
// everything toward execute. Detects load-use hazards, inserts
// LOAD_USE_STALLS bubbles and holds fetch via stall_fetch (combinational).
// Optional macro DECODE_BYPASS_EN: same-cycle writeback forwarding into rs/rt.
// Ports: clock, reset (async, active-high); insn_decode, pc, insn_valid, flush
//        from fetch/execute; wb_wren, wb_rd, wb_data from writeback;
//        stall_fetch to fetch; valid_execute, pc_execute, insn_execute,
//        rs_data, rt_data, imm_ext, rd_dest, reg_wren, mem_read, mem_wren to execute.
module decode_stage
    import mips_pkg::*;
#(
    parameter int unsigned LOAD_USE_STALLS = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [0:31] insn_decode,
    input  logic [0:31] pc,
    input  logic        insn_valid,
    input  logic        flush,
    input  logic        wb_wren,
    input  logic [0:4]  wb_rd,
    input  logic [0:31] wb_data,
    output logic        stall_fetch,
    output logic        valid_execute,
    output logic [0:31] pc_execute,
    output logic [0:31] insn_execute,
    output logic [0:31] rs_data,
    output logic [0:31] rt_data,
    output logic [0:31] imm_ext,
    output logic [0:4]  rd_dest,
    output logic        reg_wren,
    output logic        mem_read,
    output logic        mem_wren
);

    logic [0:4]  rs_c;
    logic [0:4]  rt_c;
    logic [0:31] rs_val_c;
    logic [0:31] rt_val_c;
    dec_ctrl_t   ctrl_c;
    logic        detect_c;
    logic        issue_c;

    dec_state_e       state_q,     state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic        valid_q,    valid_d;
    logic [0:31] pc_q,       pc_d;
    logic [0:31] insn_q,     insn_d;
    logic [0:31] rs_data_q,  rs_data_d;
    logic [0:31] rt_data_q,  rt_data_d;
    logic [0:31] imm_q,      imm_d;
    logic [0:4]  rd_dest_q,  rd_dest_d;
    logic        reg_wren_q, reg_wren_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_wren_q, mem_wren_d;

    assign rs_c   = insn_decode[RS_FIRST:RS_LAST];
    assign rt_c   = insn_decode[RT_FIRST:RT_LAST];
    assign ctrl_c = decode_ctrl(insn_decode);

    regfile u_regfile (
        .clock       (clock),
        .reset       (reset),
        .rd_addr_a   (rs_c),
        .rd_addr_b   (rt_c),
        .rd_data_a_c (rs_val_c),
        .rd_data_b_c (rt_val_c),
        .wr_en       (wb_wren),
        .wr_addr     (wb_rd),
        .wr_data     (wb_data)
    );

    // Load in execute whose destination feeds the instruction now in decode
    assign detect_c = (state_q == ST_RUN) && valid_q && mem_read_q &&
                      (rd_dest_q != 5'd0) && insn_valid &&
                      ((rd_dest_q == rs_c) || (ctrl_c.uses_rt && (rd_dest_q == rt_c)));

    assign stall_fetch = !flush && ((state_q == ST_HAZARD) || detect_c);

    // A real instruction moves to execute only in RUN with no hazard and no flush
    assign issue_c = !flush && (state_q == ST_RUN) && !detect_c && insn_valid;

    // Hazard FSM next state; the first bubble is issued from RUN itself
    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        if (flush) begin
            state_d     = ST_RUN;
            stall_cnt_d = '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (detect_c && (LOAD_USE_STALLS > 1)) begin
                        state_d     = ST_HAZARD;
                        stall_cnt_d = CNT_W'(LOAD_USE_STALLS - 1);
                    end
                end
                ST_HAZARD: begin
                    stall_cnt_d = CNT_W'(stall_cnt_q - CNT_W'(1));
                    if (stall_cnt_q == CNT_W'(1)) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d     = ST_RUN;
                    stall_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Execute-side payload: bubbles clear valid/control and hold the rest
    always_comb begin
        valid_d    = 1'b0;
        reg_wren_d = 1'b0;
        mem_read_d = 1'b0;
        mem_wren_d = 1'b0;
        pc_d       = pc_q;
        insn_d     = insn_q;
        rs_data_d  = rs_data_q;
        rt_data_d  = rt_data_q;
        imm_d      = imm_q;
        rd_dest_d  = rd_dest_q;
        if (issue_c) begin
            valid_d    = 1'b1;
            reg_wren_d = ctrl_c.reg_wren;
            mem_read_d = ctrl_c.mem_read;
            mem_wren_d = ctrl_c.mem_wren;
            pc_d       = pc;
            insn_d     = insn_decode;
            rs_data_d  = rs_val_c;
            rt_data_d  = rt_val_c;
            imm_d      = ctrl_c.imm_ext;
            rd_dest_d  = ctrl_c.rd_dest;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q    <= 1'b0;
            reg_wren_q <= 1'b0;
            mem_read_q <= 1'b0;
            mem_wren_q <= 1'b0;
            pc_q       <= '0;
            insn_q     <= '0;
            rs_data_q  <= '0;
            rt_data_q  <= '0;
            imm_q      <= '0;
            rd_dest_q  <= '0;
        end else begin
            valid_q    <= valid_d;
            reg_wren_q <= reg_wren_d;
            mem_read_q <= mem_read_d;
            mem_wren_q <= mem_wren_d;
            pc_q       <= pc_d;
            insn_q     <= insn_d;
            rs_data_q  <= rs_data_d;
            rt_data_q  <= rt_data_d;
            imm_q      <= imm_d;
            rd_dest_q  <= rd_dest_d;
        end
    end

    assign valid_execute = valid_q;
    assign pc_execute    = pc_q;
    assign insn_execute  = insn_q;
    assign rs_data       = rs_data_q;
    assign rt_data       = rt_data_q;
    assign imm_ext       = imm_q;
    assign rd_dest       = rd_dest_q;
    assign reg_wren      = reg_wren_q;
    assign mem_read      = mem_read_q;
    assign mem_wren      = mem_wren_q;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: two instances (1 and 3 load-use bubbles) share
// one stimulus stream; a behavioural model checks every output each cycle,
// plus literal expectations for the directed scenarios.
module tb_decode_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] insn_decode = '0;
    logic [31:0] pc = '0;
    logic        insn_valid = 1'b0;
    logic        flush = 1'b0;
    logic        wb_wren = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;

    logic        sf  [2];
    logic        ve  [2];
    logic [31:0] pce [2];
    logic [31:0] ine [2];
    logic [31:0] rsd [2];
    logic [31:0] rtd [2];
    logic [31:0] imx [2];
    logic [4:0]  rdd [2];
    logic        rw  [2];
    logic        mr  [2];
    logic        mw  [2];

    always #5 clock = ~clock;

    decode_stage #(.LOAD_USE_STALLS(1)) u_dut1 (
        .clock(clock), .reset(reset), .insn_decode(insn_decode), .pc(pc),
        .insn_valid(insn_valid), .flush(flush), .wb_wren(wb_wren), .wb_rd(wb_rd),
        .wb_data(wb_data), .stall_fetch(sf[0]), .valid_execute(ve[0]),
        .pc_execute(pce[0]), .insn_execute(ine[0]), .rs_data(rsd[0]), .rt_data(rtd[0]),
        .imm_ext(imx[0]), .rd_dest(rdd[0]), .reg_wren(rw[0]), .mem_read(mr[0]),
        .mem_wren(mw[0])
    );

    decode_stage #(.LOAD_USE_STALLS(3)) u_dut3 (
        .clock(clock), .reset(reset), .insn_decode(insn_decode), .pc(pc),
        .insn_valid(insn_valid), .flush(flush), .wb_wren(wb_wren), .wb_rd(wb_rd),
        .wb_data(wb_data), .stall_fetch(sf[1]), .valid_execute(ve[1]),
        .pc_execute(pce[1]), .insn_execute(ine[1]), .rs_data(rsd[1]), .rt_data(rtd[1]),
        .imm_ext(imx[1]), .rd_dest(rdd[1]), .reg_wren(rw[1]), .mem_read(mr[1]),
        .mem_wren(mw[1])
    );

    int n_vec = 0;
    int n_err = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_regs [32];
    bit          m_valid [2];
    logic [31:0] m_pc [2], m_insn [2], m_rs [2], m_rt [2], m_imm [2];
    logic [4:0]  m_rd [2];
    bit          m_wren [2], m_mread [2], m_mwren [2];
    int          m_pend [2];
    int          stalls [2] = '{1, 3};

    function automatic int f_op(input logic [31:0] w);    return int'(w >> 26); endfunction
    function automatic logic [4:0] f_rs(input logic [31:0] w); return 5'((w >> 21) & 32'h1F); endfunction
    function automatic logic [4:0] f_rt(input logic [31:0] w); return 5'((w >> 16) & 32'h1F); endfunction
    function automatic logic [4:0] f_rdf(input logic [31:0] w); return 5'((w >> 11) & 32'h1F); endfunction
    function automatic bit f_load(input logic [31:0] w);  return f_op(w) >= 32 && f_op(w) <= 37; endfunction
    function automatic bit f_store(input logic [31:0] w); return f_op(w) >= 40 && f_op(w) <= 43; endfunction

    function automatic logic [31:0] f_imm(input logic [31:0] w);
        logic [31:0] lo;
        lo = w & 32'hFFFF;
        if (f_op(w) >= 12 && f_op(w) <= 14) return lo;
        if (f_op(w) == 15) return lo << 16;
        return (lo >= 32'h8000) ? (lo | 32'hFFFF_0000) : lo;
    endfunction

    function automatic logic [4:0] f_dest(input logic [31:0] w);
        if (f_op(w) == 0) return f_rdf(w);
        if ((f_op(w) >= 8 && f_op(w) <= 15) || f_load(w)) return f_rt(w);
        if (f_op(w) == 3) return 5'd31;
        return 5'd0;
    endfunction

    function automatic bit f_wren(input logic [31:0] w);
        bit jr;
        jr = (f_op(w) == 0) && ((w & 32'h3F) == 32'h08);
        return (f_dest(w) != 5'd0) && !jr;
    endfunction

    function automatic bit f_uses_rt(input logic [31:0] w);
        int op;
        op = f_op(w);
        return op == 0 || f_store(w) || op == 1 || (op >= 4 && op <= 7);
    endfunction

    function automatic bit m_detect(input int k);
        if (m_pend[k] != 0 || !m_valid[k] || !m_mread[k] || m_rd[k] == 5'd0 || !insn_valid) return 1'b0;
        return (m_rd[k] == f_rs(insn_decode)) ||
               (f_uses_rt(insn_decode) && m_rd[k] == f_rt(insn_decode));
    endfunction

    function automatic bit m_stall(input int k);
        return !flush && (m_pend[k] > 0 || m_detect(k));
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
`ifdef DECODE_BYPASS_EN
        if (wb_wren && wb_rd == a) return wb_data;
`endif
        return m_regs[a];
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            for (int k = 0; k < 2; k++) begin
                m_valid[k] = 0; m_pc[k] = '0; m_insn[k] = '0; m_rs[k] = '0; m_rt[k] = '0;
                m_imm[k] = '0; m_rd[k] = '0; m_wren[k] = 0; m_mread[k] = 0; m_mwren[k] = 0;
                m_pend[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                bit issue;
                issue = 1'b0;
                if (flush) m_pend[k] = 0;
                else if (m_pend[k] > 0) m_pend[k] = m_pend[k] - 1;
                else if (m_detect(k)) m_pend[k] = stalls[k] - 1;
                else issue = insn_valid;
                m_valid[k] = issue; m_wren[k] = 0; m_mread[k] = 0; m_mwren[k] = 0;
                if (issue) begin
                    m_pc[k] = pc; m_insn[k] = insn_decode;
                    m_rs[k] = m_read(f_rs(insn_decode)); m_rt[k] = m_read(f_rt(insn_decode));
                    m_imm[k] = f_imm(insn_decode); m_rd[k] = f_dest(insn_decode);
                    m_wren[k] = f_wren(insn_decode); m_mread[k] = f_load(insn_decode);
                    m_mwren[k] = f_store(insn_decode);
                end
            end
            if (wb_wren && wb_rd != 5'd0) m_regs[wb_rd] = wb_data;
        end
    end

    // Per-cycle compare of both DUTs against the model
    always @(negedge clock) begin
        if (checking) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("dut%0d stall_fetch", k), 32'(sf[k]), 32'(m_stall(k)));
                chk($sformatf("dut%0d valid_execute", k), 32'(ve[k]), 32'(m_valid[k]));
                chk($sformatf("dut%0d pc_execute", k), pce[k], m_pc[k]);
                chk($sformatf("dut%0d insn_execute", k), ine[k], m_insn[k]);
                chk($sformatf("dut%0d rs_data", k), rsd[k], m_rs[k]);
                chk($sformatf("dut%0d rt_data", k), rtd[k], m_rt[k]);
                chk($sformatf("dut%0d imm_ext", k), imx[k], m_imm[k]);
                chk($sformatf("dut%0d rd_dest", k), 32'(rdd[k]), 32'(m_rd[k]));
                chk($sformatf("dut%0d reg_wren", k), 32'(rw[k]), 32'(m_wren[k]));
                chk($sformatf("dut%0d mem_read", k), 32'(mr[k]), 32'(m_mread[k]));
                chk($sformatf("dut%0d mem_wren", k), 32'(mw[k]), 32'(m_mwren[k]));
            end
        end
    end

    // ---------------- stimulus ----------------
    localparam logic [31:0] IDLE = 32'h0000_0000;
    localparam logic [31:0] LW9  = 32'h8D09_0000;  // LW r9,0(r8)
    localparam logic [31:0] ADD  = 32'h0129_5020;  // ADD r10,r9,r9

    // Apply one cycle of inputs just after the rising edge, then let it settle
    task automatic drive(input logic [31:0] w, input bit v, input bit fl,
                         input bit we, input logic [4:0] wr, input logic [31:0] wd,
                         input logic [31:0] p);
        @(posedge clock);
        #2;
        insn_decode = w; insn_valid = v; flush = fl;
        wb_wren = we; wb_rd = wr; wb_data = wd; pc = p;
        #1;
    endtask

    function automatic logic [31:0] rand_insn();
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3));
        rd = 5'($urandom_range(0, 3)); imm = 16'($urandom);
        case ($urandom_range(0, 12))
            0:  return {6'h00, rs, rt, rd, 5'h00, 6'h20};
            1:  return {6'h00, rs, 15'h0000, 6'h08};
            2:  return {6'h08, rs, rt, imm};
            3:  return {6'h0D, rs, rt, imm};
            4:  return {6'h0C, rs, rt, imm};
            5:  return {6'h0E, rs, rt, imm};
            6:  return {6'h0F, rs, rt, imm};
            7:  return {6'h23, rs, rt, imm};
            8:  return {6'h20, rs, rt, imm};
            9:  return {6'h2B, rs, rt, imm};
            10: return {6'h04, rs, rt, imm};
            11: return {6'h02, 26'($urandom)};
            default: return {6'h03, 26'($urandom)};
        endcase
    endfunction

    initial begin
        #1 reset = 1'b1;
        #1;
        chk("reset valid_execute", 32'(ve[0]), 32'h0);
        chk("reset stall_fetch", 32'(sf[1]), 32'h0);
        chk("reset pc_execute", pce[1], 32'h0);
        @(posedge clock); @(posedge clock);
        #2 reset = 1'b0;
        checking = 1'b1;

        // ADDI r8,r0,5
        drive(32'h2008_0005, 1, 0, 0, 0, 0, 32'h8002_0000);
        drive(IDLE, 0, 0, 0, 0, 0, 32'h0);
        chk("addi valid", 32'(ve[0]), 32'h1);
        chk("addi rd_dest", 32'(rdd[0]), 32'd8);
        chk("addi imm", imx[0], 32'h0000_0005);
        chk("addi reg_wren", 32'(rw[0]), 32'h1);
        chk("addi pc", pce[0], 32'h8002_0000);

        // Immediate extension flavours
        drive(32'h3401_FFFF, 1, 0, 0, 0, 0, 32'h10);
        drive(32'h2001_FFFF, 1, 0, 0, 0, 0, 32'h14);
        chk("ori imm", imx[0], 32'h0000_FFFF);
        drive(32'h3C01_1234, 1, 0, 0, 0, 0, 32'h18);
        chk("addi neg imm", imx[0], 32'hFFFF_FFFF);
        drive(IDLE, 0, 0, 0, 0, 0, 32'h1C);
        chk("lui imm", imx[1], 32'h1234_0000);

        // Load-use: fetch holds ADD while stalled
        drive(LW9, 1, 0, 0, 0, 0, 32'h20);
        drive(ADD, 1, 0, 0, 0, 0, 32'h24);
        chk("lu stall1 c1", 32'(sf[0]), 32'h1);
        chk("lu stall3 c1", 32'(sf[1]), 32'h1);
        drive(ADD, 1, 0, 0, 0, 0, 32'h24);
        chk("lu stall1 c2", 32'(sf[0]), 32'h0);
        chk("lu bubble1", 32'(ve[0]), 32'h0);
        chk("lu stall3 c2", 32'(sf[1]), 32'h1);
        drive(ADD, 1, 0, 0, 0, 0, 32'h24);
        chk("lu issue1", 32'(ve[0]), 32'h1);
        chk("lu issue1 insn", ine[0], ADD);
        chk("lu stall3 c3", 32'(sf[1]), 32'h1);
        chk("lu bubble3 b2", 32'(ve[1]), 32'h0);
        drive(ADD, 1, 0, 0, 0, 0, 32'h24);
        chk("lu stall3 c4", 32'(sf[1]), 32'h0);
        chk("lu bubble3 b3", 32'(ve[1]), 32'h0);
        drive(IDLE, 0, 0, 0, 0, 0, 32'h28);
        chk("lu issue3", 32'(ve[1]), 32'h1);
        chk("lu issue3 insn", ine[1], ADD);

        // Flush while the 3-bubble instance is in HAZARD
        drive(LW9, 1, 0, 0, 0, 0, 32'h30);
        drive(ADD, 1, 0, 0, 0, 0, 32'h34);
        drive(ADD, 1, 1, 0, 0, 0, 32'h34);
        chk("flush stall", 32'(sf[1]), 32'h0);
        drive(ADD, 1, 0, 0, 0, 0, 32'h34);
        chk("flush valid", 32'(ve[1]), 32'h0);
        chk("flush run", 32'(sf[1]), 32'h0);
        drive(IDLE, 0, 0, 0, 0, 0, 32'h38);
        chk("post flush issue", 32'(ve[1]), 32'h1);

        // Same-cycle writeback vs read of r5
        drive(IDLE, 0, 0, 1, 5'd5, 32'h1111_1111, 32'h40);
        drive(32'h00A0_0820, 1, 0, 1, 5'd5, 32'hDEAD_BEEF, 32'h44);
        drive(32'h00A0_0820, 1, 0, 0, 0, 0, 32'h48);
`ifdef DECODE_BYPASS_EN
        chk("wb same cycle", rsd[0], 32'hDEAD_BEEF);
`else
        chk("wb same cycle", rsd[0], 32'h1111_1111);
`endif
        drive(IDLE, 0, 0, 0, 0, 0, 32'h4C);
        chk("wb next read", rsd[0], 32'hDEAD_BEEF);

        // r0 is hardwired
        drive(IDLE, 0, 0, 1, 5'd0, 32'hFFFF_FFFF, 32'h50);
        drive(32'h0000_0820, 1, 0, 0, 0, 0, 32'h54);
        drive(IDLE, 0, 0, 0, 0, 0, 32'h58);
        chk("r0 rs", rsd[0], 32'h0);
        chk("r0 rt", rtd[1], 32'h0);

        // Random traffic with a mid-stream asynchronous reset
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                @(posedge clock);
                #2 reset = 1'b1;
                #1;
                for (int k = 0; k < 2; k++) begin
                    chk($sformatf("mid reset valid%0d", k), 32'(ve[k]), 32'h0);
                    chk($sformatf("mid reset stall%0d", k), 32'(sf[k]), 32'h0);
                    chk($sformatf("mid reset rs%0d", k), rsd[k], 32'h0);
                    chk($sformatf("mid reset imm%0d", k), imx[k], 32'h0);
                end
                @(posedge clock);
                #2 reset = 1'b0;
            end
            drive(rand_insn(), $urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)), $urandom, $urandom);
        end

        @(posedge clock);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
